screen_sequencer: RTL and testbench



---
 rtl/screen_sequencer.sv | 125 ++++++++++++
 tb/tb_screen_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/screen_sequencer.sv
// screen_sequencer: routes one of four full-screen renderers to the VGA pins with frame-synchronous fades
//   vga_clk, reset              pixel clock, async active-high reset
//   DrawX, DrawY, blank         raster position and active-video flag
//   start, lose_evt, win_evt, restart   screen-change event pulses
//   title_rgb, game_rgb, win_rgb, lose_rgb   12-bit {r,g,b} renderer outputs
//   red, green, blue            registered, brightness-scaled pixel
//   screen_sel, game_enable, fading   routed source and sequencing status
module screen_sequencer #(
  parameter int FADE_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        start,
  input  logic        lose_evt,
  input  logic        win_evt,
  input  logic        restart,
  input  logic [11:0] title_rgb,
  input  logic [11:0] game_rgb,
  input  logic [11:0] win_rgb,
  input  logic [11:0] lose_rgb,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic [1:0]  screen_sel,
  output logic        game_enable,
  output logic        fading
);
  typedef enum logic [1:0] {STEADY, FADE_OUT, FADE_IN} state_t;
  localparam int CW = FADE_FRAMES > 1 ? $clog2(FADE_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FADE_FRAMES - 1);
  localparam logic [1:0] TITLE = 2'd0, PLAY = 2'd1, WIN = 2'd2, LOSE = 2'd3;
  state_t state, state_n;
  logic [1:0] target, target_n, sel_n;
  logic [4:0] level, level_n;
  logic [CW-1:0] cnt, cnt_n;
  logic frame_tick, step_tick;
  logic [11:0] src;
  assign frame_tick = DrawX == 10'd0 && DrawY == 10'd480;
  assign step_tick = frame_tick && cnt == LAST;
  always_comb begin
    state_n = state;
    sel_n = screen_sel;
    target_n = target;
    level_n = level;
    // the counter wraps on step_tick, so entering FADE_IN from FADE_OUT also starts it at 0
    cnt_n = frame_tick ? (step_tick ? '0 : cnt + 1'b1) : cnt;
    case (state)
      STEADY: begin
        cnt_n = '0;
        if (screen_sel == TITLE && start) begin
          target_n = PLAY;
          state_n = FADE_OUT;
        end else if (screen_sel == PLAY && lose_evt) begin
          target_n = LOSE;
          state_n = FADE_OUT;
        end else if (screen_sel == PLAY && win_evt) begin
          target_n = WIN;
          state_n = FADE_OUT;
        end else if (screen_sel[1] && restart) begin
          target_n = TITLE;
          state_n = FADE_OUT;
        end
      end
      FADE_OUT: begin
        if (step_tick) begin
          if (level == 5'd0) begin
            sel_n = target;
            state_n = FADE_IN;
          end else begin
            level_n = level - 5'd1;
          end
        end
      end
      FADE_IN: begin
        if (step_tick) begin
          level_n = level + 5'd1;
          state_n = level == 5'd15 ? STEADY : FADE_IN;
        end
      end
      default: state_n = STEADY;
    endcase
  end
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state <= STEADY;
      screen_sel <= TITLE;
      target <= TITLE;
      level <= 5'd16;
      cnt <= '0;
      game_enable <= 1'b0;
      fading <= 1'b0;
    end else begin
      state <= state_n;
      screen_sel <= sel_n;
      target <= target_n;
      level <= level_n;
      cnt <= cnt_n;
      game_enable <= state == STEADY && screen_sel == PLAY;
      fading <= state != STEADY;
    end
  end
  assign src = screen_sel == TITLE ? title_rgb :
               screen_sel == PLAY  ? game_rgb  :
               screen_sel == WIN   ? win_rgb   : lose_rgb;
  // level <= 16 keeps the 9-bit product <= 240, so bits [7:4] are the whole result
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] l);
    logic [8:0] p;
    p = {5'd0, c} * {4'd0, l};
    return p[7:4];
  endfunction
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      red <= '0;
      green <= '0;
      blue <= '0;
    end else begin
      red <= blank ? scale(src[11:8], level) : '0;
      green <= blank ? scale(src[7:4], level) : '0;
      blue <= blank ? scale(src[3:0], level) : '0;
    end
  end
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: randomized and directed check of screen_sequencer against a frame-count model
module tb_screen_sequencer;
  localparam int F = 2;
  logic vga_clk = 1'b0;
  logic reset = 1'b0;
  logic [9:0] DrawX = 10'd0, DrawY = 10'd478;
  logic blank = 1'b0, start = 1'b0, lose_evt = 1'b0, win_evt = 1'b0, restart = 1'b0;
  logic [11:0] title_rgb = '0, game_rgb = '0, win_rgb = '0, lose_rgb = '0;
  logic [3:0] red, green, blue;
  logic [1:0] screen_sel;
  logic game_enable, fading;
  int errs = 0, checks = 0, pos = 0, tk = 0;
  bit m_busy = 1'b0;
  int m_k = 0;
  logic [1:0] m_screen = 2'd0, m_target = 2'd0;

  screen_sequencer #(.FADE_FRAMES(F)) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .start(start), .lose_evt(lose_evt), .win_evt(win_evt), .restart(restart),
    .title_rgb(title_rgb), .game_rgb(game_rgb), .win_rgb(win_rgb), .lose_rgb(lose_rgb),
    .red(red), .green(green), .blue(blue), .screen_sel(screen_sel),
    .game_enable(game_enable), .fading(fading)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  // brightness as a function of frame_ticks elapsed since the event was accepted
  function automatic int m_level();
    if (!m_busy) return 16;
    if (m_k < 17 * F) return 16 - m_k / F;
    return (m_k - 17 * F) / F;
  endfunction

  function automatic logic [3:0] sc(input logic [3:0] c, input int l);
    return 4'((int'(c) * l) / 16);
  endfunction

  task automatic accept(input logic [1:0] t);
    m_busy = 1'b1;
    m_k = 0;
    m_target = t;
    tk = 0;
  endtask

  task automatic step();
    logic [11:0] s, ex;
    int l;
    bit ft, exf, exg;
    l = m_level();
    s = m_screen == 2'd0 ? title_rgb : m_screen == 2'd1 ? game_rgb : m_screen == 2'd2 ? win_rgb : lose_rgb;
    ex = blank ? {sc(s[11:8], l), sc(s[7:4], l), sc(s[3:0], l)} : 12'h0;
    exf = m_busy;
    exg = !m_busy && m_screen == 2'd1;
    ft = DrawX == 10'd0 && DrawY == 10'd480;
    @(posedge vga_clk);
    if (ft) tk++;
    if (!m_busy) begin
      if (m_screen == 2'd0 && start) accept(2'd1);
      else if (m_screen == 2'd1 && lose_evt) accept(2'd3);
      else if (m_screen == 2'd1 && win_evt) accept(2'd2);
      else if (m_screen >= 2'd2 && restart) accept(2'd0);
    end else if (ft) begin
      m_k++;
      if (m_k == 17 * F) m_screen = m_target;
      if (m_k == 33 * F) m_busy = 1'b0;
    end
    #1;
    chk("rgb", {20'd0, red, green, blue}, {20'd0, ex});
    chk("screen_sel", {30'd0, screen_sel}, {30'd0, m_screen});
    chk("fading", {31'd0, fading}, {31'd0, exf});
    chk("game_enable", {31'd0, game_enable}, {31'd0, exg});
    start = 1'b0;
    lose_evt = 1'b0;
    win_evt = 1'b0;
    restart = 1'b0;
    pos = (pos + 1) % 32;
    DrawX = 10'(pos % 8);
    DrawY = 10'(478 + pos / 8);
  endtask

  task automatic run(input int n, input bit ev);
    for (int i = 0; i < n; i++) begin
      title_rgb = 12'($urandom);
      game_rgb = 12'($urandom);
      win_rgb = 12'($urandom);
      lose_rgb = 12'($urandom);
      blank = ($urandom % 8) != 0;
      if (ev) begin
        start = ($urandom % 40) == 0;
        lose_evt = ($urandom % 40) == 0;
        win_evt = ($urandom % 40) == 0;
        restart = ($urandom % 40) == 0;
      end
      step();
    end
  endtask

  task automatic until_tk(input int n);
    int g;
    g = 0;
    while (tk < n && g < 5000) begin
      run(1, 1'b0);
      g++;
    end
    chk("tick_bound", tk, n);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_rgb", {20'd0, red, green, blue}, 0);
    chk("rst_sel", {30'd0, screen_sel}, 0);
    chk("rst_fading", {31'd0, fading}, 0);
    chk("rst_ge", {31'd0, game_enable}, 0);
    #2 reset = 1'b0;
    run(40, 1'b0);
    start = 1'b1;
    step();
    run(5 * 32, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("midrst_sel", {30'd0, screen_sel}, 0);
    chk("midrst_fading", {31'd0, fading}, 0);
    chk("midrst_rgb", {20'd0, red, green, blue}, 0);
    m_busy = 1'b0;
    m_k = 0;
    m_screen = 2'd0;
    m_target = 2'd0;
    #1 reset = 1'b0;
    run(64, 1'b0);
    title_rgb = 12'hF80;
    blank = 1'b1;
    step();
    chk("title_px", {20'd0, red, green, blue}, 32'hF80);
    blank = 1'b0;
    step();
    chk("blank_px", {20'd0, red, green, blue}, 0);
    start = 1'b1;
    step();
    chk("fading_n1", {31'd0, fading}, 0);
    run(1, 1'b0);
    chk("fading_n2", {31'd0, fading}, 1);
    until_tk(2);
    title_rgb = 12'hFFF;
    blank = 1'b1;
    step();
    chk("lvl15_px", {20'd0, red, green, blue}, 32'hEEE);
    until_tk(33);
    chk("sel_tick33", {30'd0, screen_sel}, 0);
    until_tk(34);
    chk("sel_tick34", {30'd0, screen_sel}, 1);
    until_tk(50);
    game_rgb = 12'h9F1;
    blank = 1'b1;
    step();
    chk("lvl8_px", {20'd0, red, green, blue}, 32'h470);
    run(20, 1'b0);
    lose_evt = 1'b1;
    restart = 1'b1;
    step();
    until_tk(66);
    run(2, 1'b0);
    chk("play_fading", {31'd0, fading}, 0);
    chk("play_ge", {31'd0, game_enable}, 1);
    chk("play_sel", {30'd0, screen_sel}, 1);
    run(10, 1'b0);
    lose_evt = 1'b1;
    win_evt = 1'b1;
    step();
    until_tk(34);
    chk("sel_lose", {30'd0, screen_sel}, 3);
    until_tk(66);
    run(2, 1'b0);
    restart = 1'b1;
    step();
    until_tk(34);
    chk("sel_restart", {30'd0, screen_sel}, 0);
    until_tk(40);
    start = 1'b1;
    step();
    until_tk(66);
    run(2, 1'b0);
    chk("title_sel", {30'd0, screen_sel}, 0);
    chk("title_fading", {31'd0, fading}, 0);
    start = 1'b1;
    step();
    run(1, 1'b0);
    chk("start_again", {31'd0, fading}, 1);
    run(200 * 32, 1'b1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
